// File: rtl/alu_pkg.sv
// Shared constants for the ALU share arbiter: data width, ALU opcodes and
// the result-register FSM encoding.
package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_ASR = 3'b111;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu16.sv
// Single shared combinational ALU; results truncate to W bits, shift
// amounts of W or more give the natural SystemVerilog shift result.
module alu16
  import alu_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [2:0]   op_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = '0;
    case (op_i)
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_AND:  y_o = a_i & b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_LSL:  y_o = a_i << b_i;
      OP_LSR:  y_o = a_i >> b_i;
      OP_ASR:  y_o = $unsigned($signed(a_i) >>> b_i);
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr (wrapping), one-hot plus binary index; nothing granted when en is low.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_idx
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between NREQ requesters with a registered, tagged result.
// Define ALU_FLAGS_EN to add the registered rsp_flags {negative, zero} output.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int ID_W   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ*3-1:0]      req_op,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [2:0]             alu_op,
  input  logic [DATA_W-1:0]      alu_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [ID_W-1:0]        rsp_id
`ifdef ALU_FLAGS_EN
  , output logic [1:0]           rsp_flags
`endif
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] rspData_q;
  logic [ID_W-1:0]   rspId_q;
  logic              canIssue;
  logic              anyGrant;
  logic [NREQ-1:0]   gnt;
  logic [ID_W-1:0]   gntIdx;

  // Holding reset low must also block grants, so rst_n gates the arbiter.
  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) uArb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .en      (canIssue & rst_n),
    .gnt     (gnt),
    .gnt_idx (gntIdx)
  );

  assign anyGrant  = |gnt;
  assign req_ready = gnt;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        alu_a  = alu_a  | req_a[i*DATA_W +: DATA_W];
        alu_b  = alu_b  | req_b[i*DATA_W +: DATA_W];
        alu_op = alu_op | req_op[i*3 +: 3];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (anyGrant) state_d = ST_FULL;
      ST_FULL:  if (!anyGrant && rsp_ready) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    canIssue  = (state_q == ST_EMPTY) | rsp_ready;
    rsp_valid = (state_q == ST_FULL);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (anyGrant) ptr_d = (int'(gntIdx) == NREQ-1) ? '0 : gntIdx + ID_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      rspData_q <= '0;
      rspId_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (anyGrant) begin
        rspData_q <= alu_result;
        rspId_q   <= gntIdx;
      end
    end
  end

  assign rsp_data = rspData_q;
  assign rsp_id   = rspId_q;

`ifdef ALU_FLAGS_EN
  logic [1:0] flags_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        flags_q <= 2'b01;
    else if (anyGrant) flags_q <= {alu_result[DATA_W-1], (alu_result == '0)};
  end

  assign rsp_flags = flags_q;
`endif

endmodule
